flex_updown_counter: RTL and testbench
======================================

FLEX_UPDOWN_COUNTER -- requirements
Module: flex_updown_counter

Interface
REQ-001 Parameter: NUM_CNT_BITS, default 4, counter width in bits (>=2).
REQ-002 Parameter: START_VAL, default 1, restart value after an up-wrap and the low boundary for down-counting.
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: clear  input  1  synchronous clear; highest-priority control.
REQ-006 Port: load  input  1  synchronous load of load_val.
REQ-007 Port: load_val  input  NUM_CNT_BITS  value captured on load.
REQ-008 Port: count_enable  input  1  advance the count by one step.
REQ-009 Port: dir  input  1  1 = count up, 0 = count down.
REQ-010 Port: sat_mode  input  1  1 = saturate at boundary, 0 = wrap.
REQ-011 Port: rollover_val  input  NUM_CNT_BITS  upper boundary, sampled every cycle.
REQ-012 Port: count_out  output  NUM_CNT_BITS  registered count.
REQ-013 Port: rollover_flag  output  1  registered; high while count_out == rollover_val.
REQ-014 Port: bottom_flag  output  1  registered; high while count_out == START_VAL.
REQ-015 Port: wrap_pulse  output  1  registered one-cycle pulse; high in the cycle after a wrap occurred.

Function
REQ-016 Priority is clear > load > count_enable; with none of them asserted, count_out holds.
REQ-017 clear: next count_out = 0; rollover_flag, bottom_flag and wrap_pulse are forced to 0 for that update, regardless of equality.
REQ-018 load (no clear): next count_out = load_val, with no range check; wrap_pulse = 0.
REQ-019 Up step (count_enable, dir=1), when count_out < rollover_val: next = count_out + 1.
REQ-020 Up step at the boundary (count_out >= rollover_val): with sat_mode=0, next = START_VAL and a wrap occurs; with sat_mode=1, count holds and no wrap occurs.
REQ-021 Down step (count_enable, dir=0), when count_out > START_VAL: next = count_out - 1.
REQ-022 Down step at the boundary (count_out <= START_VAL): with sat_mode=0, next = rollover_val and a wrap occurs; with sat_mode=1, count holds and no wrap occurs.
REQ-023 Illegal configuration (rollover_val < START_VAL): count_enable steps are suppressed and the count holds; clear and load still act, and flags still follow REQ-024.
REQ-024 Flags other than on clear: rollover_flag <= (next count == rollover_val); bottom_flag <= (next count == START_VAL); both update every cycle, including hold cycles.
REQ-025 wrap_pulse <= 1 only for an update in which REQ-020 or REQ-022 wrapped; otherwise 0. It never stays high for two consecutive cycles unless consecutive wraps occur.
REQ-026 Arithmetic is modulo 2^NUM_CNT_BITS internally; the boundary checks of REQ-020 and REQ-022 guarantee that no natural overflow or underflow is ever visible on count_out.
REQ-027 A change of dir, sat_mode or rollover_val takes effect on the next rising edge, with no additional latency.
REQ-028 There is no combinational path from any input to any output; all outputs are flops.

Reset
REQ-029 While n_rst = 0: count_out = 0, rollover_flag = 0, bottom_flag = 0, wrap_pulse = 0; assertion is immediate, independent of clk.
REQ-030 Reset asserted mid-count discards the count; the first edge after deassertion evaluates from count 0 per REQ-016..REQ-025.

Verification (NUM_CNT_BITS=4, START_VAL=1)
REQ-031 Up-wrap: reset, then rollover_val=4, dir=1, sat_mode=0, enable held -> count_out 0,1,2,3,4,1,2; rollover_flag high only while count_out=4; wrap_pulse high only in the cycle count_out returns to 1; bottom_flag high while count_out=1.
REQ-032 Down-wrap: load_val=2 with load for 1 cycle, then dir=0, enable held, rollover_val=4 -> count_out 2,1,4,3,2,1,4; wrap_pulse high in each cycle count_out shows 4 after a step from 1.
REQ-033 Saturate: rollover_val=4, dir=1, sat_mode=1, enable held for 8 cycles from 0 -> count_out 1,2,3,4,4,4,4,4; rollover_flag stays high from the first 4 onward; wrap_pulse stays 0.
REQ-034 Simultaneous events: with count_out=3, assert clear, load (load_val=9) and enable in one cycle -> count_out=0 and all flags 0; next cycle, with load and enable only -> count_out=9.
REQ-035 Out-of-range load: rollover_val=4, load_val=7, dir=1, sat_mode=0; after the load, enable one cycle -> count_out 7 then 1, with wrap_pulse=1.
REQ-036 Reset mid-operation: at count_out=3 with rollover_flag=0, pulse n_rst low between clock edges -> all outputs 0 immediately; after release, enable resumes 1,2,...

Source files
------------

// File: rtl/flex_updown_counter.sv
// ---------------------------------------------------------------------------
// flex_updown_counter
//
// Parameterised up/down counter with a runtime-programmable upper boundary
// (rollover_val), a fixed lower boundary (START_VAL), and wrap-or-saturate
// behaviour at either boundary. Every output is a flop.
//
// Parameters
//   NUM_CNT_BITS  counter width (>= 2)
//   START_VAL     restart value after an up-wrap; lower boundary when counting down
//
// Ports
//   clk            in   clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   clear          in   synchronous clear to 0 (highest priority)
//   load           in   synchronous load of load_val
//   load_val       in   value captured on load (no range check)
//   count_enable   in   take one step in direction dir
//   dir            in   1 = up, 0 = down
//   sat_mode       in   1 = hold at boundary, 0 = wrap
//   rollover_val   in   upper boundary, sampled every cycle
//   count_out      out  registered count
//   rollover_flag  out  count_out == rollover_val
//   bottom_flag    out  count_out == START_VAL
//   wrap_pulse     out  high for the cycle after a wrap
// ---------------------------------------------------------------------------
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4,
  parameter int START_VAL    = 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    dir,
  input  logic                    sat_mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    bottom_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] START_V = NUM_CNT_BITS'(START_VAL);
  localparam logic [NUM_CNT_BITS-1:0] ONE_V   = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    rollover_q, rollover_d;
  logic                    bottom_q, bottom_d;
  logic                    wrap_q, wrap_d;
  logic                    cfg_ok;

  // A boundary pair with rollover_val below START_VAL has no valid range,
  // so stepping is frozen until software fixes it; clear/load still work.
  assign cfg_ok = (rollover_val >= START_V);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    rollover_d = 1'b0;
    bottom_d   = 1'b0;

    if (clear) begin
      count_d = '0;
    end else begin
      if (load) begin
        count_d = load_val;
      end else if (count_enable && cfg_ok) begin
        if (dir) begin
          // >= rather than == so an out-of-range loaded value wraps back
          // into range instead of overflowing naturally.
          if (count_q < rollover_val) begin
            count_d = count_q + ONE_V;
          end else if (!sat_mode) begin
            count_d = START_V;
            wrap_d  = 1'b1;
          end
        end else begin
          if (count_q > START_V) begin
            count_d = count_q - ONE_V;
          end else if (!sat_mode) begin
            count_d = rollover_val;
            wrap_d  = 1'b1;
          end
        end
      end

      // Flags track the value being registered, so they line up with count_out.
      rollover_d = (count_d == rollover_val);
      bottom_d   = (count_d == START_V);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      bottom_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      bottom_q   <= bottom_d;
      wrap_q     <= wrap_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_q;
  assign bottom_flag   = bottom_q;
  assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
module tb_flex_updown_counter;

  localparam int W  = 4;
  localparam int SV = 1;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         clear, load, count_enable, dir, sat_mode;
  logic [W-1:0] load_val, rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag, bottom_flag, wrap_pulse;

  flex_updown_counter #(.NUM_CNT_BITS(W), .START_VAL(SV)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .dir          (dir),
    .sat_mode     (sat_mode),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .bottom_flag  (bottom_flag),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         rf;
    logic         bf;
    logic         wp;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;

  task automatic compare(input exp_t e);
    n_tests++;
    if (count_out !== e.cnt || rollover_flag !== e.rf ||
        bottom_flag !== e.bf || wrap_pulse !== e.wp) begin
      n_fail++;
      $display("FAIL %s @%0t: got cnt=%0d rf=%0b bf=%0b wp=%0b, expected cnt=%0d rf=%0b bf=%0b wp=%0b",
               e.tag, $time, count_out, rollover_flag, bottom_flag, wrap_pulse,
               e.cnt, e.rf, e.bf, e.wp);
    end
  endtask

  // Reference model: counts as a plain integer using the boundary rules.
  function automatic exp_t predict();
    exp_t e;
    int   rv  = int'(rollover_val);
    int   nxt = m_cnt;
    bit   w   = 1'b0;
    e.tag = "";
    if (clear) begin
      m_cnt = 0;
      e.cnt = '0; e.rf = 1'b0; e.bf = 1'b0; e.wp = 1'b0;
      return e;
    end
    if (load) nxt = int'(load_val);
    else if (count_enable && rv >= SV) begin
      if (dir) begin
        if (m_cnt < rv) nxt = m_cnt + 1;
        else if (!sat_mode) begin nxt = SV; w = 1'b1; end
      end else begin
        if (m_cnt > SV) nxt = m_cnt - 1;
        else if (!sat_mode) begin nxt = rv; w = 1'b1; end
      end
    end
    m_cnt = nxt;
    e.cnt = W'(nxt);
    e.rf  = (nxt == rv);
    e.bf  = (nxt == SV);
    e.wp  = w;
    return e;
  endfunction

  task automatic drive(input bit c, input bit l, input logic [W-1:0] lv,
                       input bit en, input bit d, input bit s, input logic [W-1:0] rv);
    clear = c; load = l; load_val = lv; count_enable = en;
    dir = d; sat_mode = s; rollover_val = rv;
  endtask

  task automatic step(input bit c, input bit l, input logic [W-1:0] lv,
                      input bit en, input bit d, input bit s, input logic [W-1:0] rv,
                      input string tag);
    exp_t e;
    @(negedge clk);
    drive(c, l, lv, en, d, s, rv);
    e = predict();
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Directed step: expectation written out by hand; model still advances.
  task automatic step_x(input bit c, input bit l, input logic [W-1:0] lv,
                        input bit en, input bit d, input bit s, input logic [W-1:0] rv,
                        input logic [W-1:0] ec, input bit erf, input bit ebf, input bit ewp,
                        input string tag);
    exp_t e, m;
    @(negedge clk);
    drive(c, l, lv, en, d, s, rv);
    m = predict();
    e.cnt = ec; e.rf = erf; e.bf = ebf; e.wp = ewp; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Pulse reset between edges, check the outputs drop at once, then queue
  // the expectation for the first edge after release (idle inputs).
  task automatic reset_pulse(input logic [W-1:0] rv, input string tag);
    exp_t e;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, rv);
    #2 n_rst = 1'b0;
    #1;
    e.cnt = '0; e.rf = 1'b0; e.bf = 1'b0; e.wp = 1'b0; e.tag = tag;
    compare(e);
    #1 n_rst = 1'b1;
    m_cnt = 0;
    e = predict();
    e.tag = {tag, "_post"};
    sb_q.push_back(e);
  endtask

  // Monitor: one registered result per clock, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    bit           r_dir, r_sat;
    logic [W-1:0] r_rv;
    n_rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd4);

    reset_pulse(4'd4, "reset_init");

    // Up-wrap: 1,2,3,4,1,2
    step_x(0,0,0,1,1,0,4'd4, 4'd1,0,1,0, "upwrap_1");
    step_x(0,0,0,1,1,0,4'd4, 4'd2,0,0,0, "upwrap_2");
    step_x(0,0,0,1,1,0,4'd4, 4'd3,0,0,0, "upwrap_3");
    step_x(0,0,0,1,1,0,4'd4, 4'd4,1,0,0, "upwrap_4");
    step_x(0,0,0,1,1,0,4'd4, 4'd1,0,1,1, "upwrap_wrap");
    step_x(0,0,0,1,1,0,4'd4, 4'd2,0,0,0, "upwrap_2b");

    // Down-wrap: load 2, then 1,4,3,2,1,4
    step_x(0,1,4'd2,0,0,0,4'd4, 4'd2,0,0,0, "down_load");
    step_x(0,0,0,1,0,0,4'd4, 4'd1,0,1,0, "down_1");
    step_x(0,0,0,1,0,0,4'd4, 4'd4,1,0,1, "down_wrap");
    step_x(0,0,0,1,0,0,4'd4, 4'd3,0,0,0, "down_3");
    step_x(0,0,0,1,0,0,4'd4, 4'd2,0,0,0, "down_2");
    step_x(0,0,0,1,0,0,4'd4, 4'd1,0,1,0, "down_1b");
    step_x(0,0,0,1,0,0,4'd4, 4'd4,1,0,1, "down_wrap2");

    // Saturate from 0
    reset_pulse(4'd4, "reset_sat");
    step_x(0,0,0,1,1,1,4'd4, 4'd1,0,1,0, "sat_1");
    step_x(0,0,0,1,1,1,4'd4, 4'd2,0,0,0, "sat_2");
    step_x(0,0,0,1,1,1,4'd4, 4'd3,0,0,0, "sat_3");
    for (int i = 0; i < 5; i++)
      step_x(0,0,0,1,1,1,4'd4, 4'd4,1,0,0, "sat_hold");
    // Saturate at the bottom when counting down
    step(0,1,4'd1,0,0,1,4'd4, "satdn_load");
    step_x(0,0,0,1,0,1,4'd4, 4'd1,0,1,0, "satdn_hold");

    // Simultaneous clear/load/enable
    step_x(0,1,4'd3,0,1,0,4'd4, 4'd3,0,0,0, "sim_load3");
    step_x(1,1,4'd9,1,1,0,4'd4, 4'd0,0,0,0, "sim_clear");
    step_x(0,1,4'd9,1,1,0,4'd4, 4'd9,0,0,0, "sim_load9");

    // Out-of-range load then up step wraps to START_VAL
    step_x(0,1,4'd7,0,1,0,4'd4, 4'd7,0,0,0, "oor_load");
    step_x(0,0,0,1,1,0,4'd4, 4'd1,0,1,1, "oor_wrap");

    // Illegal config: rollover below START_VAL freezes stepping
    step_x(0,1,4'd0,0,1,0,4'd0, 4'd0,1,0,0, "illegal_load");
    step_x(0,0,0,1,1,0,4'd0, 4'd0,1,0,0, "illegal_hold");

    // Reset mid-operation at count 3
    step_x(0,1,4'd3,0,1,0,4'd4, 4'd3,0,0,0, "midrst_load3");
    reset_pulse(4'd4, "reset_mid");
    step_x(0,0,0,1,1,0,4'd4, 4'd1,0,1,0, "midrst_1");
    step_x(0,0,0,1,1,0,4'd4, 4'd2,0,0,0, "midrst_2");

    // Randomized phase against the model
    r_dir = 1'b1; r_sat = 1'b0; r_rv = 4'd6;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        r_rv = ($urandom_range(0, 11) == 0) ? 4'd0 : W'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0)  r_dir = ~r_dir;
      if ($urandom_range(0, 9) == 0)  r_sat = ~r_sat;
      if ($urandom_range(0, 149) == 0)
        reset_pulse(r_rv, "rand_reset");
      else
        step($urandom_range(0, 29) == 0,
             $urandom_range(0, 14) == 0,
             W'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0,
             r_dir, r_sat, r_rv, "rand");
    end

    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, r_rv);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
